// File: rtl/smvm_pkg.sv
// Shared types for the sparse matrix-vector row accumulator.
package smvm_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DRAIN   = 2'd1,
    READOUT = 2'd2
  } acc_state_t;

  // Cycles needed for a beat accepted with finish to land in y.
  localparam int DRAIN_CYCLES = 2;

  typedef struct packed {
    logic [31:0] value;
    logic [31:0] col_id;
    logic [31:0] row_id;
  } lane_beat_t;

endpackage

// File: rtl/smvm_row_accumulator_lane_multiplier.sv
// Per-lane multiply: registers the S0 lookup into S1, then the low 32 bits of value*x into S2.
// Two-cycle latency, no stalls; row id and lane-valid travel alongside the product.
module lane_multiplier #(
  parameter int NUM_CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic [NUM_CHANNELS-1:0]      vld_i,
  input  logic [NUM_CHANNELS-1:0][31:0] value_i,
  input  logic [NUM_CHANNELS-1:0][31:0] x_i,
  input  logic [NUM_CHANNELS-1:0][31:0] row_i,
  output logic [NUM_CHANNELS-1:0]      vld_o,
  output logic [NUM_CHANNELS-1:0][31:0] prod_o,
  output logic [NUM_CHANNELS-1:0][31:0] row_o
);

  logic [NUM_CHANNELS-1:0]       s1_vld_q, s2_vld_q;
  logic [NUM_CHANNELS-1:0][31:0] s1_val_q, s1_x_q, s1_row_q;
  logic [NUM_CHANNELS-1:0][31:0] s2_prod_q, s2_prod_d, s2_row_q;

  always_comb begin
    s2_prod_d = '0;
    for (int l = 0; l < NUM_CHANNELS; l++) begin
      s2_prod_d[l] = s1_val_q[l] * s1_x_q[l];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_vld_q  <= '0;
      s1_val_q  <= '0;
      s1_x_q    <= '0;
      s1_row_q  <= '0;
      s2_vld_q  <= '0;
      s2_prod_q <= '0;
      s2_row_q  <= '0;
    end else begin
      s1_vld_q  <= vld_i;
      s1_val_q  <= value_i;
      s1_x_q    <= x_i;
      s1_row_q  <= row_i;
      s2_vld_q  <= s1_vld_q;
      s2_prod_q <= s2_prod_d;
      s2_row_q  <= s1_row_q;
    end
  end

  assign vld_o  = s2_vld_q;
  assign prod_o = s2_prod_q;
  assign row_o  = s2_row_q;

endmodule

// File: rtl/smvm_row_accumulator.sv
// Multiplies decoder beats by x[col_id], accumulates into y[row_id], then streams y out on finish.
// Beat-to-y latency 3 edges; in_ready low outside ACCUM, readout stalls on out_ready.
module smvm_row_accumulator
  import smvm_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int VEC_DEPTH    = 8,
  parameter int NUM_ROWS     = 8
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          x_wr_en,
  input  logic [$clog2(VEC_DEPTH)-1:0]  x_wr_addr,
  input  logic [31:0]                   x_wr_data,
  input  logic                          in_valid,
  input  logic [NUM_CHANNELS-1:0][31:0] in_values,
  input  logic [NUM_CHANNELS-1:0][31:0] in_col_id,
  input  logic [NUM_CHANNELS-1:0][31:0] in_row_id,
  output logic                          in_ready,
  input  logic                          finish,
  output logic                          out_valid,
  output logic [31:0]                   out_data,
  output logic [$clog2(NUM_ROWS)-1:0]   out_row,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          err_col_range,
  output logic                          err_row_range,
  output logic                          err_overrun
);

  localparam int XAW = $clog2(VEC_DEPTH);
  localparam int RAW = $clog2(NUM_ROWS);

  acc_state_t     state_q, state_d;
  logic [1:0]     drain_cnt_q, drain_cnt_d;
  logic [RAW-1:0] rd_ptr_q, rd_ptr_d;
  logic           clear_y;

  logic [31:0] x_q [VEC_DEPTH];
  logic [31:0] y_q [NUM_ROWS];
  logic [31:0] y_d [NUM_ROWS];
  logic        err_col_q, err_row_q, err_ovr_q;

  logic                          accept;
  lane_beat_t                    beat_s0 [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]       lane_vld, col_bad;
  logic [NUM_CHANNELS-1:0][31:0] lane_val, lane_x, lane_row;
  logic [NUM_CHANNELS-1:0]       s2_vld;
  logic [NUM_CHANNELS-1:0][31:0] s2_prod, s2_row;
  logic                          row_bad;

  assign in_ready = (state_q == ACCUM);
  assign busy     = ~in_ready;
  assign accept   = in_valid & in_ready;

  // S0: x lookup reads the registered file, so a same-cycle write is not yet visible.
  always_comb begin
    lane_vld = '0;
    lane_val = '0;
    lane_x   = '0;
    lane_row = '0;
    col_bad  = '0;
    for (int l = 0; l < NUM_CHANNELS; l++) begin
      beat_s0[l] = '{value: in_values[l], col_id: in_col_id[l], row_id: in_row_id[l]};
      lane_vld[l] = accept;
      lane_val[l] = beat_s0[l].value;
      lane_row[l] = beat_s0[l].row_id;
      if (beat_s0[l].col_id < 32'(VEC_DEPTH)) begin
        lane_x[l] = x_q[beat_s0[l].col_id[XAW-1:0]];
      end else begin
        col_bad[l] = accept;
      end
    end
  end

  lane_multiplier #(.NUM_CHANNELS(NUM_CHANNELS)) u_mult (
    .clk     (clk),
    .rst_l   (rst_l),
    .vld_i   (lane_vld),
    .value_i (lane_val),
    .x_i     (lane_x),
    .row_i   (lane_row),
    .vld_o   (s2_vld),
    .prod_o  (s2_prod),
    .row_o   (s2_row)
  );

  // S2 row-match adder: every lane hitting a row adds in, so collisions never lose data.
  always_comb begin
    row_bad = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      y_d[r] = y_q[r];
      for (int l = 0; l < NUM_CHANNELS; l++) begin
        if (s2_vld[l] && (s2_row[l] == 32'(r))) y_d[r] = y_d[r] + s2_prod[l];
      end
      if (clear_y) y_d[r] = '0;
    end
    for (int l = 0; l < NUM_CHANNELS; l++) begin
      if (s2_vld[l] && (s2_row[l] >= 32'(NUM_ROWS))) row_bad = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    clear_y     = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (finish) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == 2'd0) state_d = READOUT;
        else                     drain_cnt_d = drain_cnt_q - 2'd1;
      end
      READOUT: begin
        if (out_ready) begin
          if (rd_ptr_q == RAW'(NUM_ROWS - 1)) begin
            rd_ptr_d = '0;
            clear_y  = 1'b1;
            state_d  = ACCUM;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ACCUM;
      drain_cnt_q <= '0;
      rd_ptr_q    <= '0;
      err_col_q   <= 1'b0;
      err_row_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
      for (int i = 0; i < VEC_DEPTH; i++) x_q[i] <= '0;
      for (int r = 0; r < NUM_ROWS; r++)  y_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      err_col_q   <= err_col_q | (|col_bad);
      err_row_q   <= err_row_q | row_bad;
      err_ovr_q   <= err_ovr_q | ((state_q != ACCUM) & (in_valid | finish));
      if (x_wr_en) x_q[x_wr_addr] <= x_wr_data;
      for (int r = 0; r < NUM_ROWS; r++) y_q[r] <= y_d[r];
    end
  end

  assign out_valid     = (state_q == READOUT);
  assign out_row       = rd_ptr_q;
  assign out_data      = out_valid ? y_q[rd_ptr_q] : '0;
  assign out_last      = out_valid & (rd_ptr_q == RAW'(NUM_ROWS - 1));
  assign err_col_range = err_col_q;
  assign err_row_range = err_row_q;
  assign err_overrun   = err_ovr_q;

endmodule

// File: tb/tb_smvm_row_accumulator.sv
// Directed bench for smvm_row_accumulator with a reference y model feeding an expected-output queue.
module tb_smvm_row_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_l, x_wr_en, in_valid, in_ready, finish;
  logic [2:0]       x_wr_addr;
  logic [31:0]      x_wr_data;
  logic [3:0][31:0] in_values, in_col_id, in_row_id;
  logic             out_valid, out_last, out_ready, busy;
  logic [31:0]      out_data;
  logic [2:0]       out_row;
  logic             err_col_range, err_row_range, err_overrun;

  smvm_row_accumulator #(.NUM_CHANNELS(4), .VEC_DEPTH(8), .NUM_ROWS(8)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .x_wr_en       (x_wr_en),
    .x_wr_addr     (x_wr_addr),
    .x_wr_data     (x_wr_data),
    .in_valid      (in_valid),
    .in_values     (in_values),
    .in_col_id     (in_col_id),
    .in_row_id     (in_row_id),
    .in_ready      (in_ready),
    .finish        (finish),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .busy          (busy),
    .err_col_range (err_col_range),
    .err_row_range (err_row_range),
    .err_overrun   (err_overrun)
  );

  typedef struct {
    logic [2:0]  row;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] xm [8];
  logic [31:0] ym [8];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_x(input int a, input logic [31:0] d);
    x_wr_en   = 1'b1;
    x_wr_addr = 3'(a);
    x_wr_data = d;
    xm[a]     = d;
    tick();
    x_wr_en   = 1'b0;
  endtask

  task automatic push_result();
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{row: 3'(i), data: ym[i], last: (i == 7)});
      ym[i] = '0;
    end
  endtask

  task automatic beat(input logic [3:0][31:0] v, input logic [3:0][31:0] c,
                      input logic [3:0][31:0] r, input logic fin);
    chk("in_ready_before_beat", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_values = v;
    in_col_id = c;
    in_row_id = r;
    finish    = fin;
    for (int l = 0; l < 4; l++) begin
      if (r[l] < 32'd8) ym[r[l][2:0]] += v[l] * ((c[l] < 32'd8) ? xm[c[l][2:0]] : 32'd0);
    end
    tick();
    in_valid = 1'b0;
    finish   = 1'b0;
    if (fin) push_result();
  endtask

  task automatic fin_only();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    push_result();
  endtask

  // Reads n words; at stall_row holds out_ready low 5 cycles while poking in_valid.
  task automatic readout(input int n, input int stall_row);
    exp_t e;
    int   k;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) break;
      out_ready = 1'b1;
      k = 0;
      while (!out_valid && k < 20) begin
        tick();
        k++;
      end
      chk("out_valid", 32'(out_valid), 32'd1);
      e = sb.pop_front();
      chk("out_row", 32'(out_row), 32'(e.row));
      chk("out_data", out_data, e.data);
      chk("out_last", 32'(out_last), 32'(e.last));
      chk("in_ready_in_readout", 32'(in_ready), 32'd0);
      if (int'(e.row) == stall_row) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_values = {4{32'd9}};
        in_col_id = {4{32'd0}};
        in_row_id = {4{32'd4}};
        for (int s = 0; s < 5; s++) begin
          tick();
          in_valid = 1'b0;
          chk("hold_row", 32'(out_row), 32'(e.row));
          chk("hold_data", out_data, e.data);
        end
        chk("err_overrun_set", 32'(err_overrun), 32'd1);
        out_ready = 1'b1;
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0; x_wr_en = 1'b0; x_wr_addr = '0; x_wr_data = '0;
    in_valid = 1'b0; in_values = '0; in_col_id = '0; in_row_id = '0;
    finish = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin xm[i] = '0; ym[i] = '0; end
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_errs", {29'd0, err_col_range, err_row_range, err_overrun}, 32'd0);
    rst_l = 1'b1;
    tick();

    // Basic product
    for (int i = 0; i < 8; i++) wr_x(i, 32'(i + 1));
    beat({32'd5, 32'd4, 32'd3, 32'd2}, {32'd3, 32'd2, 32'd1, 32'd0}, {32'd3, 32'd2, 32'd1, 32'd0}, 1'b0);
    fin_only();
    readout(8, -1);
    chk("basic_in_ready_back", 32'(in_ready), 32'd1);
    chk("basic_out_valid_low", 32'(out_valid), 32'd0);

    // Row collision
    wr_x(7, 32'd10);
    beat({32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd7}}, {4{32'd5}}, 1'b0);
    fin_only();
    readout(8, -1);

    // Back-to-back with finish on the third beat, then backpressure at row 2
    beat({4{32'd1}}, {32'd3, 32'd2, 32'd1, 32'd0}, {32'd3, 32'd2, 32'd1, 32'd0}, 1'b0);
    beat({4{32'd2}}, {32'd7, 32'd6, 32'd5, 32'd4}, {32'd7, 32'd6, 32'd5, 32'd4}, 1'b0);
    beat({4{32'd1}}, {4{32'd0}}, {4{32'd7}}, 1'b1);
    chk("fin_t0_out_valid", 32'(out_valid), 32'd0);
    chk("fin_t0_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("fin_t2_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("fin_t3_out_valid", 32'(out_valid), 32'd1);
    chk("err_overrun_clear", 32'(err_overrun), 32'd0);
    readout(8, 2);

    // Range and wrap
    beat({32'd1, 32'd3, 32'd7, 32'hFFFF_FFFF}, {32'd0, 32'd2, 32'd9, 32'd1},
         {32'd6, 32'd8, 32'd1, 32'd0}, 1'b0);
    chk("err_col_set", 32'(err_col_range), 32'd1);
    chk("err_row_not_yet", 32'(err_row_range), 32'd0);
    tick();
    tick();
    chk("err_row_set", 32'(err_row_range), 32'd1);
    fin_only();
    readout(8, -1);

    // Reset mid-readout
    beat({4{32'd5}}, {4{32'd0}}, {4{32'd3}}, 1'b0);
    fin_only();
    readout(3, -1);
    chk("pre_rst_row3", 32'(out_row), 32'd3);
    rst_l = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_errs", {29'd0, err_col_range, err_row_range, err_overrun}, 32'd0);
    sb.delete();
    for (int i = 0; i < 8; i++) begin xm[i] = '0; ym[i] = '0; end
    tick();
    rst_l = 1'b1;
    tick();
    wr_x(0, 32'd3);
    beat({32'd0, 32'd0, 32'd0, 32'd2}, {4{32'd0}}, {4{32'd1}}, 1'b0);
    fin_only();
    readout(8, -1);
    chk("final_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
